// File: rtl/seq_priority_encoder.sv
// Registered priority scanner: accepts one multi-hot vector at a time and emits the
// index of every set bit in priority order, one per valid/ready transfer.
module seq_priority_encoder #(
    parameter int  N         = 16,
    parameter bit  LSB_FIRST = 1'b1,
    localparam int W         = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [N-1:0] in_vec,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [W:0]   out_total,
    output logic         zero_err,
    output logic         dbg_state
);

    // Handshakes: a transfer occurs on a rising edge where valid && ready. in_ready
    // depends on state, enable and rst only; out_valid is held until its transfer.

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t         state, state_d;
    logic [N-1:0]   pending, pending_d;
    logic [W:0]     total_d;
    logic           zero_d;
    logic [W-1:0]   sel_idx;
    logic [N-1:0]   sel_mask;
    logic           pend_single;
    logic           accept, xfer;

    function automatic logic [W:0] popcount(input logic [N-1:0] v);
        logic [W:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // The last hit in loop order wins, so the loop direction sets the priority.
    always_comb begin
        sel_idx  = '0;
        sel_mask = '0;
        if (LSB_FIRST) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pending[i]) begin
                    sel_idx  = W'(i);
                    sel_mask = {{(N-1){1'b0}}, 1'b1} << i;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pending[i]) begin
                    sel_idx  = W'(i);
                    sel_mask = {{(N-1){1'b0}}, 1'b1} << i;
                end
            end
        end
    end

    assign pend_single = (pending != '0) && ((pending & (pending - 1'b1)) == '0);

    assign out_valid = (state == SCAN);
    assign in_ready  = (state == IDLE) && enable && !rst;
    assign out_idx   = sel_idx;
    assign out_last  = out_valid && pend_single;
    assign dbg_state = state;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_d   = state;
        pending_d = pending;
        total_d   = out_total;
        zero_d    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_vec != '0) begin
                        pending_d = in_vec;
                        total_d   = popcount(in_vec);
                        state_d   = SCAN;
                    end else begin
                        total_d = '0;
                        zero_d  = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (xfer) begin
                    pending_d = pending & ~sel_mask;
                    if (out_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            out_total <= '0;
            zero_err  <= 1'b0;
        end else begin
            state     <= state_d;
            pending   <= pending_d;
            out_total <= total_d;
            zero_err  <= zero_d;
        end
    end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Scoreboard bench for seq_priority_encoder: an LSB-first and an MSB-first instance
// share one stimulus stream; each has its own expected queue and monitor.
module tb_seq_priority_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] in_vec = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic        l_in_ready, l_out_valid, l_out_last, l_zero_err, l_dbg;
    logic [3:0]  l_out_idx;
    logic [4:0]  l_out_total;
    logic        m_in_ready, m_out_valid, m_out_last, m_zero_err, m_dbg;
    logic [3:0]  m_out_idx;
    logic [4:0]  m_out_total;

    int n_vec = 0;
    int n_err = 0;

    // entry = {idx[3:0], last, total[4:0]}
    logic [9:0] exp_l[$];
    logic [9:0] exp_m[$];
    logic [9:0] got_l, got_m;

    seq_priority_encoder #(.N(16), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .enable(enable), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(l_in_ready), .out_idx(l_out_idx), .out_valid(l_out_valid),
        .out_ready(out_ready), .out_last(l_out_last), .out_total(l_out_total),
        .zero_err(l_zero_err), .dbg_state(l_dbg)
    );

    seq_priority_encoder #(.N(16), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .enable(enable), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(m_in_ready), .out_idx(m_out_idx), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_last(m_out_last), .out_total(m_out_total),
        .zero_err(m_zero_err), .dbg_state(m_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Bit-walk model: collects set bits, then queues them in each priority order.
    task automatic push_expected(input logic [15:0] vec);
        int bits[$];
        logic [4:0] tot;
        for (int i = 0; i < 16; i++) if (vec[i]) bits.push_back(i);
        tot = 5'(bits.size());
        for (int k = 0; k < bits.size(); k++) begin
            exp_l.push_back({4'(bits[k]), (k == bits.size() - 1), tot});
            exp_m.push_back({4'(bits[bits.size() - 1 - k]), (k == bits.size() - 1), tot});
        end
    endtask

    // monitors: compare on every cycle an output is presented, pop on transfer
    always @(negedge clk) begin
        if (!rst && l_out_valid) begin
            n_vec++;
            got_l = {l_out_idx, l_out_last, l_out_total};
            if (exp_l.size() == 0) begin
                n_err++;
                $display("FAIL lsb_unexpected got=%0h exp=none", got_l);
            end else begin
                if (got_l !== exp_l[0]) begin
                    n_err++;
                    $display("FAIL lsb_%s got=%0h exp=%0h", out_ready ? "xfer" : "stall", got_l, exp_l[0]);
                end
                if (out_ready) void'(exp_l.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && m_out_valid) begin
            n_vec++;
            got_m = {m_out_idx, m_out_last, m_out_total};
            if (exp_m.size() == 0) begin
                n_err++;
                $display("FAIL msb_unexpected got=%0h exp=none", got_m);
            end else begin
                if (got_m !== exp_m[0]) begin
                    n_err++;
                    $display("FAIL msb_%s got=%0h exp=%0h", out_ready ? "xfer" : "stall", got_m, exp_m[0]);
                end
                if (out_ready) void'(exp_m.pop_front());
            end
        end
    end

    // driver: wait for in_ready (bounded), present one vector for one accept edge
    task automatic send(input logic [15:0] vec);
        int cnt = 0;
        while (!(l_in_ready && m_in_ready) && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("send_in_ready", {31'b0, l_in_ready && m_in_ready}, 32'd1);
        in_vec   = vec;
        in_valid = 1'b1;
        push_expected(vec);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (vec != 16'h0) begin
            chk("latency_l", {31'b0, l_out_valid}, 32'd1);
            chk("latency_m", {31'b0, m_out_valid}, 32'd1);
        end
    endtask

    task automatic drain(input bit toggle, output int cycles);
        cycles = 0;
        while ((exp_l.size() != 0 || exp_m.size() != 0) && cycles < 300) begin
            if (toggle) out_ready = ~out_ready;
            @(posedge clk); #1;
            cycles++;
        end
        out_ready = 1'b1;
        chk("drain_left", 32'(exp_l.size() + exp_m.size()), 32'd0);
        chk("idle_in_ready", {30'b0, l_in_ready, m_in_ready}, 32'd3);
        chk("idle_out_valid", {30'b0, l_out_valid, m_out_valid}, 32'd0);
    endtask

    initial begin
        int cyc;
        // reset values while rst is held
        #2;
        chk("rst_in_ready", {30'b0, l_in_ready, m_in_ready}, 32'd0);
        chk("rst_out_valid", {30'b0, l_out_valid, m_out_valid}, 32'd0);
        chk("rst_out_idx", {24'b0, l_out_idx, m_out_idx}, 32'd0);
        chk("rst_out_last", {30'b0, l_out_last, m_out_last}, 32'd0);
        chk("rst_out_total", {22'b0, l_out_total, m_out_total}, 32'd0);
        chk("rst_zero_err", {30'b0, l_zero_err, m_zero_err}, 32'd0);
        chk("rst_state", {30'b0, l_dbg, m_dbg}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 8421: lsb 0,5,10,15 / msb 15,10,5,0, one per cycle
        send(16'h8421);
        drain(1'b0, cyc);
        chk("8421_cycles", 32'(cyc), 32'd4);
        chk("8421_total_held", {27'b0, l_out_total}, 32'd4);

        // all-zero vector: one-cycle zero_err, no output, total cleared
        send(16'h0000);
        chk("zero_err_set", {30'b0, l_zero_err, m_zero_err}, 32'd3);
        chk("zero_out_valid", {30'b0, l_out_valid, m_out_valid}, 32'd0);
        chk("zero_in_ready", {30'b0, l_in_ready, m_in_ready}, 32'd3);
        chk("zero_total", {22'b0, l_out_total, m_out_total}, 32'd0);
        @(posedge clk); #1;
        chk("zero_err_pulse", {30'b0, l_zero_err, m_zero_err}, 32'd0);

        // walking one: each a single transfer with last=1, total=1
        for (int i = 0; i < 16; i++) begin
            send(16'h0001 << i);
            drain(1'b0, cyc);
            chk("walk_cycles", 32'(cyc), 32'd1);
        end

        // all ones under toggling backpressure
        send(16'hFFFF);
        drain(1'b1, cyc);
        chk("ffff_total", {27'b0, l_out_total}, 32'd16);

        // reset after two of four transfers of 00F0
        send(16'h00F0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_left_l", 32'(exp_l.size()), 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {30'b0, l_out_valid, m_out_valid}, 32'd0);
        exp_l.delete();
        exp_m.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_state", {30'b0, l_dbg, m_dbg}, 32'd0);
        chk("post_rst_total", {22'b0, l_out_total, m_out_total}, 32'd0);
        chk("post_rst_idx", {24'b0, l_out_idx, m_out_idx}, 32'd0);
        send(16'h0003);
        drain(1'b0, cyc);
        chk("0003_cycles", 32'(cyc), 32'd2);

        // enable low in IDLE: nothing accepted
        enable   = 1'b0;
        in_vec   = 16'h0003;
        in_valid = 1'b1;
        #1;
        chk("en_low_in_ready", {30'b0, l_in_ready, m_in_ready}, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("en_low_out_valid", {30'b0, l_out_valid, m_out_valid}, 32'd0);
        chk("en_low_zero_err", {30'b0, l_zero_err, m_zero_err}, 32'd0);
        chk("en_low_state", {30'b0, l_dbg, m_dbg}, 32'd0);
        in_valid = 1'b0;
        enable   = 1'b1;
        #1;
        chk("en_high_in_ready", {30'b0, l_in_ready, m_in_ready}, 32'd3);
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
